sprite_draw_scheduler: RTL and testbench
========================================

Name: sprite_draw_scheduler

Overview:
- Shares one sprite ROM and the single VGA plot port between NUM_REQ sprite requesters (pacman, ghosts, pellet erase).
- Arbitrates requests round-robin, latches the winner's position and sprite id, then raster-scans the SPRITE_W x SPRITE_H sprite.
- Emits one plot per pixel, compensating for the 1-cycle ROM read latency, and acknowledges the requester when the draw is complete.

Parameters:
- NUM_REQ, 4, number of requesters.
- SPRITE_W, 5, sprite width in pixels.
- SPRITE_H, 5, sprite height in pixels.
- SPRITE_SEL_W, 2, sprite id width (up to 4 sprites in ROM, stored back to back).
- ADDR_W, 7, ROM address width (4*25 = 100 words).
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped.
- TRANSPARENT, 1, if 1 then ROM colour 0 is not plotted.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester draw request; held high until matching ack
- req_x  in  NUM_REQ*8  packed start x, slot i at [8i+7:8i]
- req_y  in  NUM_REQ*7  packed start y
- req_sprite  in  NUM_REQ*SPRITE_SEL_W  packed sprite id
- ack  out  NUM_REQ  one-hot, one-cycle pulse when the granted draw finishes
- busy  out  1  high in every state except IDLE
- rom_addr  out  ADDR_W  sprite ROM address
- rom_q  in  3  ROM colour, valid the cycle after rom_addr
- vga_x  out  8  plot x
- vga_y  out  7  plot y
- vga_colour  out  3  plot colour
- vga_plot  out  1  plot strobe

Behaviour:
- Reset (reset==0 at a clock edge), regardless of current state:
  - state=IDLE; ack=0; vga_plot=0; vga_x/vga_y/vga_colour=0; rom_addr=0.
  - rr_last=NUM_REQ-1, so req[0] has first priority.
  - An in-progress draw is abandoned and never acked.
- FSM states: IDLE, SCAN, DRAIN, ACK.
- IDLE:
  - If any req is high, grant the first set bit searching rr_last+1, rr_last+2, ... modulo NUM_REQ.
  - Latch gx=req_x, gy=req_y, gsel=req_sprite for the winner; col=0, row=0; go to SCAN.
- SCAN (exactly SPRITE_W*SPRITE_H cycles):
  - rom_addr = gsel*SPRITE_W*SPRITE_H + row*SPRITE_W + col.
  - col increments each cycle; at col==SPRITE_W-1, col=0 and row increments.
  - After issuing col==SPRITE_W-1, row==SPRITE_H-1, go to DRAIN.
- Plot pipeline:
  - Pixel coordinates px=gx+col (9-bit sum) and py=gy+row (8-bit sum) are registered alongside rom_addr.
  - One cycle later: vga_plot=1 iff px<SCREEN_W and py<SCREEN_H and not (TRANSPARENT and rom_q==0).
  - vga_x=px[7:0], vga_y=py[6:0], vga_colour=rom_q.
  - No coordinate wrap-around: clipped pixels are suppressed, not wrapped.
- DRAIN: one cycle; the last pixel's plot decision occurs here. Go to ACK.
- ACK:
  - ack[grant]=1 for this cycle only; rr_last=grant; go to IDLE.
- Timing: if a grant happens in cycle G, then:
  - SCAN is cycles G+1..G+25.
  - vga_plot may be high in cycles G+2..G+26.
  - ack is high in cycle G+27.
  - The next grant is possible at G+28.
- Request handling:
  - Requester must drop req in the cycle after ack; a req still high at G+28 is treated as a new request.
  - req dropped mid-draw: the draw still completes and is acked.
  - req_x/req_y/req_sprite changes after grant are ignored (values are latched).
  - Simultaneous requests are granted round-robin with no starvation: every waiting requester is served within NUM_REQ draws.
- vga_plot is 0 in IDLE and ACK.

Decomposition:
- Package sprite_pkg:
  - Sprite dimensions, SCREEN_W/SCREEN_H, colour width (3), coordinate widths (8/7).
  - State encoding enum {IDLE, SCAN, DRAIN, ACK}.
- Sub-module rr_arbiter:
  - Inputs: req vector and rr_last.
  - Outputs: one-hot grant and encoded grant index.
  - Combinational; the pointer register stays in the scheduler.

Test Plan:
- Reset then req=0001, x=10, y=20, sprite 0, ROM all colour 3 -> rom_addr 0..24 in order; 25 plots spanning (10..14, 20..24) row-major; ack=0001 exactly 27 cycles after the grant.
- req=1111 held, re-raised after each ack -> grant order 0,1,2,3,0; each ack one-hot; no plot overlap between draws.
- req=0001, x=157, y=118 -> only pixels x 157..159 and y 118..119 plotted (6 strobes); ack still at G+27.
- sprite id 2, ROM word 50 = 0, others 5, TRANSPARENT=1 -> first pixel of that draw has no strobe, 24 strobes total; rom_addr starts at 50.
- Assert reset at SCAN cycle 10 -> the next cycle has vga_plot=0, ack=0, busy=0; after release with req=0010, grant goes to requester 1 and the draw starts from pixel 0.
- Drop req[0] mid-draw and change req_x[0] -> the draw completes at the originally latched position; ack[0] is still pulsed.

Source files
------------

// File: rtl/sprite_draw_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
// Shared constants and types for the sprite draw scheduler.
//   - Default sprite geometry, ROM addressing and screen limits
//   - Colour and coordinate widths of the VGA plot port
//   - FSM state encoding used by the scheduler
// ---------------------------------------------------------------------------
package sprite_pkg;

   // Default geometry; the top level exposes these as overridable parameters
   localparam int DEF_NUM_REQ      = 4;
   localparam int DEF_SPRITE_W     = 5;
   localparam int DEF_SPRITE_H     = 5;
   localparam int DEF_SPRITE_SEL_W = 2;
   localparam int DEF_ADDR_W       = 7;
   localparam int DEF_SCREEN_W     = 160;
   localparam int DEF_SCREEN_H     = 120;
   localparam int DEF_TRANSPARENT  = 1;

   // Widths of the VGA plot port
   localparam int COLOUR_W = 3;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;

   // Scheduler states
   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      ACK
   } state_t;

endpackage

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Searches the request vector starting
// one position after the last served requester and wraps around.
// Ports:
//   i_req      - request vector
//   i_rrLast   - index of the requester served most recently
//   o_grant    - one-hot grant (all zero when nothing is requested)
//   o_grantIdx - encoded index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter
   import sprite_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = 2
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_rrLast,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grantIdx
);

   logic             w_found;
   logic [IDX_W-1:0] w_idx;

   // Walk the requesters in priority order (rrLast+1, rrLast+2, ...) and
   // keep the first one that is asserting; the last-served slot is checked
   // last so nobody can be starved.
   always_comb begin
      o_grant    = '0;
      o_grantIdx = '0;
      w_found    = 1'b0;
      w_idx      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_idx = IDX_W'((int'(i_rrLast) + i) % NUM_REQ);
         if (!w_found && i_req[w_idx]) begin
            w_found        = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_grantIdx     = w_idx;
         end
      end
   end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_draw_scheduler
// Shares one sprite ROM and the VGA plot port between several requesters.
// A round-robin winner has its position and sprite id latched, its sprite is
// raster-scanned out of the ROM and plotted one pixel per cycle, and the
// requester receives a one-cycle ack once the last pixel has been handled.
// Ports:
//   clock, reset      - system clock, synchronous active-low reset
//   i_req             - per-requester draw request, held until ack
//   i_reqX/Y/Sprite   - packed per-requester start position and sprite id
//   o_ack             - one-hot one-cycle pulse when the draw is finished
//   o_busy            - high whenever the scheduler is not idle
//   o_romAddr, i_romQ - sprite ROM port (data valid one cycle after address)
//   o_vgaX/Y/Colour   - plot coordinates and colour
//   o_vgaPlot         - plot strobe
// ---------------------------------------------------------------------------
module sprite_draw_scheduler
   import sprite_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int SPRITE_W     = DEF_SPRITE_W,
   parameter int SPRITE_H     = DEF_SPRITE_H,
   parameter int SPRITE_SEL_W = DEF_SPRITE_SEL_W,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int SCREEN_W     = DEF_SCREEN_W,
   parameter int SCREEN_H     = DEF_SCREEN_H,
   parameter int TRANSPARENT  = DEF_TRANSPARENT
)(
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               i_req,
   input  logic [NUM_REQ*X_W-1:0]           i_reqX,
   input  logic [NUM_REQ*Y_W-1:0]           i_reqY,
   input  logic [NUM_REQ*SPRITE_SEL_W-1:0]  i_reqSprite,
   output logic [NUM_REQ-1:0]               o_ack,
   output logic                             o_busy,
   output logic [ADDR_W-1:0]                o_romAddr,
   input  logic [COLOUR_W-1:0]              i_romQ,
   output logic [X_W-1:0]                   o_vgaX,
   output logic [Y_W-1:0]                   o_vgaY,
   output logic [COLOUR_W-1:0]              o_vgaColour,
   output logic                             o_vgaPlot
);

   localparam int IDX_W      = (NUM_REQ  > 1) ? $clog2(NUM_REQ)  : 1;
   localparam int COL_W      = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int ROW_W      = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam int SPRITE_PIX = SPRITE_W * SPRITE_H;

   localparam logic [X_W:0]       SCREEN_X_LIM = (X_W + 1)'(SCREEN_W);
   localparam logic [Y_W:0]       SCREEN_Y_LIM = (Y_W + 1)'(SCREEN_H);
   localparam logic [COL_W-1:0]   LAST_COL     = COL_W'(SPRITE_W - 1);
   localparam logic [ROW_W-1:0]   LAST_ROW     = ROW_W'(SPRITE_H - 1);

   state_t                    r_state;
   state_t                    w_nextState;

   logic [IDX_W-1:0]          r_rrLast;
   logic [IDX_W-1:0]          r_grantIdx;
   logic [NUM_REQ-1:0]        r_grant;
   logic [X_W-1:0]            r_gx;
   logic [Y_W-1:0]            r_gy;
   logic [SPRITE_SEL_W-1:0]   r_gsel;
   logic [COL_W-1:0]          r_col;
   logic [ROW_W-1:0]          r_row;
   logic [X_W:0]              r_px;
   logic [Y_W:0]              r_py;
   logic                      r_pixValid;

   logic [NUM_REQ-1:0]        w_grant;
   logic [IDX_W-1:0]          w_grantIdx;
   logic                      w_anyReq;
   logic                      w_lastPix;
   logic [ADDR_W-1:0]         w_scanAddr;
   logic [X_W:0]              w_px;
   logic [Y_W:0]              w_py;
   logic                      w_inside;
   logic                      w_opaque;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arbiter (
      .i_req      (i_req),
      .i_rrLast   (r_rrLast),
      .o_grant    (w_grant),
      .o_grantIdx (w_grantIdx)
   );

   assign w_anyReq   = |w_grant;
   assign w_lastPix  = (r_col == LAST_COL) && (r_row == LAST_ROW);
   assign w_scanAddr = ADDR_W'(int'(r_gsel) * SPRITE_PIX + int'(r_row) * SPRITE_W + int'(r_col));

   // Coordinates are widened by one bit so that pixels running off the right
   // or bottom edge are clipped instead of wrapping back onto the screen.
   assign w_px = {1'b0, r_gx} + (X_W + 1)'(r_col);
   assign w_py = {1'b0, r_gy} + (Y_W + 1)'(r_row);

   // The ROM answers one cycle after the address, so the plot decision uses
   // the coordinates registered alongside that address plus the fresh ROM data.
   assign w_inside    = (r_px < SCREEN_X_LIM) && (r_py < SCREEN_Y_LIM);
   assign w_opaque    = !((TRANSPARENT != 0) && (i_romQ == '0));
   assign o_vgaPlot   = r_pixValid && w_inside && w_opaque;
   assign o_vgaX      = r_px[X_W-1:0];
   assign o_vgaY      = r_py[Y_W-1:0];
   assign o_vgaColour = r_pixValid ? i_romQ : '0;

   // State register; reset drops any draw in flight without acking it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic plus the state-decoded outputs. The ROM address is only
   // driven while scanning; DRAIN exists so the final pixel's ROM data can
   // still be plotted before the ack goes out.
   always_comb begin
      w_nextState = r_state;
      o_busy      = 1'b1;
      o_ack       = '0;
      o_romAddr   = '0;
      unique case (r_state)
         IDLE: begin
            o_busy = 1'b0;
            if (w_anyReq) begin
               w_nextState = SCAN;
            end
         end
         SCAN: begin
            o_romAddr = w_scanAddr;
            if (w_lastPix) begin
               w_nextState = DRAIN;
            end
         end
         DRAIN: begin
            w_nextState = ACK;
         end
         ACK: begin
            o_ack       = r_grant;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath: latch the winner's request on grant, step the raster counters
   // while scanning, pipeline pixel coordinates to line up with the ROM data,
   // and move the round-robin pointer once the draw has been acknowledged.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_rrLast   <= IDX_W'(NUM_REQ - 1);
         r_grantIdx <= '0;
         r_grant    <= '0;
         r_gx       <= '0;
         r_gy       <= '0;
         r_gsel     <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_px       <= '0;
         r_py       <= '0;
         r_pixValid <= 1'b0;
      end else begin
         r_pixValid <= (r_state == SCAN);
         if (r_state == IDLE && w_anyReq) begin
            r_grantIdx <= w_grantIdx;
            r_grant    <= w_grant;
            r_gx       <= i_reqX[int'(w_grantIdx) * X_W +: X_W];
            r_gy       <= i_reqY[int'(w_grantIdx) * Y_W +: Y_W];
            r_gsel     <= i_reqSprite[int'(w_grantIdx) * SPRITE_SEL_W +: SPRITE_SEL_W];
            r_col      <= '0;
            r_row      <= '0;
         end
         if (r_state == SCAN) begin
            r_px <= w_px;
            r_py <= w_py;
            if (r_col == LAST_COL) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         if (r_state == ACK) begin
            r_rrLast <= r_grantIdx;
         end
      end
   end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sprite_draw_scheduler
// Directed self-checking bench for sprite_draw_scheduler. A behavioural
// 1-cycle-latency ROM feeds the DUT; expected pixels are pushed to a queue
// as each ROM address is issued and popped when the plot port answers.
// ---------------------------------------------------------------------------
module tb_sprite_draw_scheduler;

   localparam int NUM_REQ = 4;

   logic                 clock;
   logic                 reset;
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ*8-1:0] reqX;
   logic [NUM_REQ*7-1:0] reqY;
   logic [NUM_REQ*2-1:0] reqSprite;
   logic [NUM_REQ-1:0]   ack;
   logic                 busy;
   logic [6:0]           romAddr;
   logic [2:0]           romQ;
   logic [7:0]           vgaX;
   logic [6:0]           vgaY;
   logic [2:0]           vgaColour;
   logic                 vgaPlot;

   logic [2:0]           rom [0:127];

   int nAsserts = 0;
   int nFails   = 0;

   typedef struct {
      bit plot;
      int x;
      int y;
      int colour;
   } pix_t;

   pix_t expQ[$];

   sprite_draw_scheduler dut (
      .clock       (clock),
      .reset       (reset),
      .i_req       (req),
      .i_reqX      (reqX),
      .i_reqY      (reqY),
      .i_reqSprite (reqSprite),
      .o_ack       (ack),
      .o_busy      (busy),
      .o_romAddr   (romAddr),
      .i_romQ      (romQ),
      .o_vgaX      (vgaX),
      .o_vgaY      (vgaY),
      .o_vgaColour (vgaColour),
      .o_vgaPlot   (vgaPlot)
   );

   // Free-running clock, 10 time units per cycle
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous ROM model: data appears the cycle after the address
   always @(posedge clock) begin
      romQ <= rom[romAddr];
   end

   // Hard stop in case the DUT wedges somewhere no bounded wait covers
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired nAsserts=%0d", nAsserts);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int slot, input bit r, input int x, input int y, input int sel);
      req[slot]             = r;
      reqX[8*slot +: 8]     = 8'(x);
      reqY[7*slot +: 7]     = 7'(y);
      reqSprite[2*slot +: 2] = 2'(sel);
   endtask

   task automatic applyReset();
      req   = '0;
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic fillRom(input int val);
      for (int i = 0; i < 128; i++) rom[i] = 3'(val);
   endtask

   // Follows one whole draw from its grant to its ack. Entry may be in the
   // ACK cycle of a previous draw, so first wait for IDLE, then for SCAN.
   task automatic checkDraw(input string name, input int idx, input int x, input int y,
                            input int sel, input bit dropMid, input int expStrobes);
      int   n;
      int   strobes;
      int   modelStrobes;
      int   addr;
      pix_t e;
      n = 0;
      while (busy !== 1'b0 && n < 100) begin @(negedge clock); n++; end
      n = 0;
      while (busy !== 1'b1 && n < 100) begin @(negedge clock); n++; end
      if (busy !== 1'b1) begin
         checkOutput({name, "_grantTimeout"}, 32'(busy), 1);
         return;
      end
      strobes      = 0;
      modelStrobes = 0;
      for (int c = 1; c <= 27; c++) begin
         if (c > 1) @(negedge clock);
         if (c <= 25) begin
            addr = sel * 25 + (c - 1);
            checkOutput({name, "_romAddr"}, 32'(romAddr), 32'(addr));
            e.x      = x + (c - 1) % 5;
            e.y      = y + (c - 1) / 5;
            e.colour = int'(rom[addr]);
            e.plot   = (e.x < 160) && (e.y < 120) && (e.colour != 0);
            if (e.plot) modelStrobes++;
            expQ.push_back(e);
         end
         if (c >= 2 && c <= 26) begin
            if (expQ.size() == 0) begin
               checkOutput({name, "_sbEmpty"}, 32'(expQ.size()), 1);
            end else begin
               e = expQ.pop_front();
               checkOutput({name, "_plot"}, 32'(vgaPlot), 32'(e.plot));
               if (e.plot) begin
                  checkOutput({name, "_x"}, 32'(vgaX), 32'(e.x & 255));
                  checkOutput({name, "_y"}, 32'(vgaY), 32'(e.y & 127));
                  checkOutput({name, "_colour"}, 32'(vgaColour), 32'(e.colour));
               end
            end
            if (vgaPlot === 1'b1) strobes++;
         end else begin
            checkOutput({name, "_plotIdle"}, 32'(vgaPlot), 0);
         end
         if (c == 27) checkOutput({name, "_ack"}, 32'(ack), 32'(1) << idx);
         else         checkOutput({name, "_ackLow"}, 32'(ack), 0);
         if (dropMid && c == 13) begin
            applyStimulus(idx, 1'b0, x + 50, y + 30, sel + 1);
         end
      end
      req[idx] = 1'b0;
      if (expStrobes >= 0) checkOutput({name, "_strobes"}, 32'(strobes), 32'(expStrobes));
      else                 checkOutput({name, "_strobes"}, 32'(strobes), 32'(modelStrobes));
   endtask

   initial begin
      int n;
      reset     = 1'b0;
      req       = '0;
      reqX      = '0;
      reqY      = '0;
      reqSprite = '0;
      fillRom(3);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // Reset state
      checkOutput("rstBusy", 32'(busy), 0);
      checkOutput("rstAck", 32'(ack), 0);
      checkOutput("rstPlot", 32'(vgaPlot), 0);
      checkOutput("rstRomAddr", 32'(romAddr), 0);
      checkOutput("rstVgaX", 32'(vgaX), 0);
      checkOutput("rstVgaY", 32'(vgaY), 0);
      checkOutput("rstColour", 32'(vgaColour), 0);

      // Basic draw fully on screen
      $display("[TB] basic draw");
      applyStimulus(0, 1'b1, 10, 20, 0);
      checkDraw("basic", 0, 10, 20, 0, 1'b0, 25);

      // All four requesting: round-robin order 0,1,2,3,0
      $display("[TB] round robin");
      applyReset();
      for (int i = 0; i < 128; i++) rom[i] = 3'((i * 3 + 1) % 8);
      for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b1, 5 + 30 * i, 50 + 10 * i, i);
      checkDraw("rr0", 0, 5, 50, 0, 1'b0, -1);
      @(negedge clock); req[0] = 1'b1;
      checkDraw("rr1", 1, 35, 60, 1, 1'b0, -1);
      @(negedge clock); req[1] = 1'b1;
      checkDraw("rr2", 2, 65, 70, 2, 1'b0, -1);
      @(negedge clock); req[2] = 1'b1;
      checkDraw("rr3", 3, 95, 80, 3, 1'b0, -1);
      checkDraw("rr4", 0, 5, 50, 0, 1'b0, -1);
      req = '0;

      // Clipping at the bottom-right corner
      $display("[TB] clipping");
      fillRom(3);
      applyStimulus(0, 1'b1, 157, 118, 0);
      checkDraw("clip", 0, 157, 118, 0, 1'b0, 6);

      // Transparent first pixel of sprite 2
      $display("[TB] transparency");
      fillRom(5);
      rom[50] = 3'd0;
      applyStimulus(2, 1'b1, 60, 60, 2);
      checkDraw("transp", 2, 60, 60, 2, 1'b0, 24);

      // Request dropped and position changed mid-draw
      $display("[TB] drop mid draw");
      applyStimulus(0, 1'b1, 30, 40, 1);
      checkDraw("drop", 0, 30, 40, 1, 1'b1, -1);

      // Reset in the middle of a scan abandons the draw
      $display("[TB] reset mid scan");
      @(negedge clock);
      applyStimulus(0, 1'b1, 40, 40, 1);
      n = 0;
      while (busy !== 1'b1 && n < 100) begin @(negedge clock); n++; end
      checkOutput("midGrant", 32'(busy), 1);
      repeat (9) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("midRstPlot", 32'(vgaPlot), 0);
      checkOutput("midRstAck", 32'(ack), 0);
      checkOutput("midRstBusy", 32'(busy), 0);
      checkOutput("midRstRomAddr", 32'(romAddr), 0);
      reset = 1'b1;
      req   = '0;
      applyStimulus(1, 1'b1, 70, 30, 3);
      checkDraw("afterRst", 1, 70, 30, 3, 1'b0, -1);
      checkOutput("finalQueue", 32'(expQ.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
